// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 4-stage 8-bit core.
// Tracks EX/MEM producers and drives registered operand-select codes plus a combinational stall.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_a,
  input  logic [REG_AW-1:0] id_rs_b,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic              id_wr,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0]       SEL_RF  = 2'b00;
  localparam logic [1:0]       SEL_EXM = 2'b01;
  localparam logic [1:0]       SEL_MWB = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              ex_vld, ex_wr, ex_ld;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_vld, mem_wr, mem_ld;
  logic [REG_AW-1:0] mem_rd;

  logic              haz;
  logic              ex_fwd_ok, mem_fwd_ok;
  logic [1:0]        sel_a, sel_b;

  // A load still in EX cannot feed its consumer yet; that case becomes the single stall bubble.
  always_comb begin
    haz = id_valid & ex_vld & ex_wr & ex_ld &
          ((id_use_a & (id_rs_a == ex_rd)) | (id_use_b & (id_rs_b == ex_rd)));
    stall = haz & ~flush & rst_n;
  end

  // Nearest producer wins, so the EX record is checked before the MEM record.
  always_comb begin
    ex_fwd_ok  = ex_vld & ex_wr & ~ex_ld;
    mem_fwd_ok = mem_vld & mem_wr;

    sel_a = SEL_RF;
    if (id_valid && id_use_a) begin
      if (ex_fwd_ok && (ex_rd == id_rs_a))
        sel_a = SEL_EXM;
      else if (mem_fwd_ok && (mem_rd == id_rs_a))
        sel_a = SEL_MWB;
    end

    sel_b = SEL_RF;
    if (id_valid && id_use_b) begin
      if (ex_fwd_ok && (ex_rd == id_rs_b))
        sel_b = SEL_EXM;
      else if (mem_fwd_ok && (mem_rd == id_rs_b))
        sel_b = SEL_MWB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld    <= 1'b0;
      ex_wr     <= 1'b0;
      ex_rd     <= '0;
      ex_ld     <= 1'b0;
      mem_vld   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_rd    <= '0;
      mem_ld    <= 1'b0;
      fwd_a     <= SEL_RF;
      fwd_b     <= SEL_RF;
      stall_cnt <= '0;
    end else begin
      mem_vld <= ex_vld;
      mem_wr  <= ex_wr;
      mem_rd  <= ex_rd;
      mem_ld  <= ex_ld;

      if (flush || stall) begin
        ex_vld <= 1'b0;
        ex_wr  <= 1'b0;
        ex_rd  <= '0;
        ex_ld  <= 1'b0;
        fwd_a  <= SEL_RF;
        fwd_b  <= SEL_RF;
      end else begin
        ex_vld <= id_valid;
        ex_wr  <= id_wr;
        ex_rd  <= id_rd;
        ex_ld  <= id_is_load;
        fwd_a  <= sel_a;
        fwd_b  <= sel_b;
      end

      // Saturating performance counter: holds at all-ones instead of wrapping.
      if (stall && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 8-bit pipelined core (ID -> EX -> MEM -> WB).
- Tracks the destination register of in-flight instructions in a small internal scoreboard.
- Generates the registered 2-bit operand-select codes for both EX-stage operand forwarding muxes, and the load-use stall to the fetch/decode stages.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_AW, 2, register address width (2**REG_AW architectural registers).
- CNT_W, 8, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- id_valid  input  1  ID holds a valid instruction.
- id_rs_a  input  REG_AW  source register of operand A.
- id_rs_b  input  REG_AW  source register of operand B.
- id_use_a  input  1  instruction reads operand A.
- id_use_b  input  1  instruction reads operand B.
- id_wr  input  1  instruction writes a register.
- id_rd  input  REG_AW  destination register.
- id_is_load  input  1  instruction is a memory load.
- flush  input  1  branch/jump taken; discard ID instruction.
- stall  output  1  hold PC and IF/ID, insert bubble into EX (combinational).
- fwd_a  output  2  operand A select for the instruction now in EX: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB data.
- fwd_b  output  2  operand B select, same encoding.
- stall_cnt  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Scoreboard has two records, EX and MEM. Each record holds: vld, wr, rd, ld.
- Reset (async, rst_n=0):
  - Both records cleared.
  - fwd_a = fwd_b = 00.
  - stall_cnt = 0.
  - stall = 0 regardless of inputs.
- Load-use hazard (combinational): haz = id_valid & ex.vld & ex.wr & ex.ld & ((id_use_a & id_rs_a==ex.rd) | (id_use_b & id_rs_b==ex.rd)).
- stall = haz & ~flush. flush has priority over stall.
- Every rising clk, MEM <= EX.
- EX update, every rising clk:
  - flush=1 or stall=1: EX <= bubble (vld=0) and fwd_a/fwd_b <= 00.
  - otherwise: EX <= {id_valid, id_wr, id_rd, id_is_load}; fwd_x <= sel(rs_x, use_x).
- sel(rs, use), evaluated against the records before the edge:
  - 00 if ~use or ~id_valid.
  - 01 if EX record is vld & wr & ~ld & rd==rs (producer ends up in MEM, result in EX/MEM).
  - 10 if MEM record is vld & wr & rd==rs (producer ends up in WB; covers loads after the 1-cycle stall).
  - else 00.
  - Nearest producer wins: 01 over 10.
- An EX load that matches while stall=0 never occurs, since that condition is exactly the stall.
- Latency: stall has 0 cycles latency. fwd_x is valid in the same cycle the consumer occupies EX, i.e. one edge after it leaves ID.
- Only a single load-use bubble is needed. After one stall cycle the load sits in MEM and the consumer gets 10.
- stall_cnt increments by 1 on each edge where stall=1, saturates at all-ones, and never wraps.
- id_wr=0 instructions (stores, branches) never become producers.
- Reset asserted mid-stall clears the stall immediately. The pipeline resumes with no forwarding.
- No register is hardwired. Register 0 forwards like any other register.

Test Plan:
- ALU back-to-back: ADD r1 (wr, rd=1) then SUB rs_a=1 on the next cycle -> when SUB is in EX, fwd_a=01, fwd_b=00, stall=0.
- Distance 2: ADD r2, NOP, then OR rs_b=2 -> fwd_b=10 when OR is in EX.
- Double hazard: ADD r1 then ADD r1 then AND rs_a=1 -> fwd_a=01 (nearest wins).
- Load-use: LD r3 then ADD rs_a=3 -> stall=1 for exactly 1 cycle, EX bubble, then fwd_a=10; stall_cnt=1.
- Flush during hazard: LD r3 then ADD rs_a=3 with flush=1 -> stall=0, EX bubble, fwd=00, stall_cnt unchanged.
- Saturation and reset: force 300 consecutive stall cycles -> stall_cnt=255. Drop rst_n mid-stall -> stall_cnt=0 and fwd=00 immediately, without waiting for clk.
